edit_sequencer: RTL
===================

# edit_sequencer

Control stage directly upstream of the output buffer stage. It accepts one intercepted 32-bit word per transaction, captures a snapshot, and drives the output buffer in two phases. First, a one-cycle bulk load. Then one cycle per stored edit instruction, each a conditional single-bit write at a 5-bit address. The edit program is held in a small register file loaded through a config port, and completion is signalled with a one-cycle `out_valid` pulse.

## Interface
- `DEPTH`, 16, number of edit-instruction slots (power of two, 2..32)
- `IDX_W`, $clog2(DEPTH), slot index width
- `clk` in 1: clock
- `reset` in 1: reset, asynchronous, active-high
- `cfg_we` in 1: write `cfg_instr` into slot `cfg_idx`
- `cfg_idx` in IDX_W: slot index
- `cfg_instr` in 13: {cond_en[12], cond_pol[11], cond_sel[10:6], val[5], addr[4:0]}
- `cfg_len_we` in 1: write program length
- `cfg_len` in IDX_W+1: number of active slots
- `in_valid` in 1: intercepted word available
- `in_data` in 32: intercepted word
- `in_ready` out 1: sequencer can accept a word
- `snap_data` out 32: captured word; feeds downstream `in_data`
- `addr` out 5: edit bit address
- `val` out 1: edit bit value
- `do_write` out 1: edit condition result
- `en_edit` out 1: edit phase strobe
- `en_load_input` out 1: bulk-load strobe
- `mux_data` out 1: 0 selects snapshot, 1 selects `val`
- `busy` out 1: transaction in progress
- `out_valid` out 1: downstream buffer holds the final result (1-cycle pulse)

## Operation
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid`, capture `in_data` into `snap_data`, clear `pc`, go to LOAD.
  - LOAD: `en_load_input`=1, `mux_data`=0. Next state is EDIT if `prog_len`≠0, otherwise DONE.
  - EDIT: `en_edit`=1, `mux_data`=1, `addr`/`val` come from slot `pc`. `pc` increments each cycle. Leave to DONE after slot `prog_len`−1.
  - DONE: `out_valid`=1 for one cycle, then go to IDLE.
- Condition: `do_write` = !cond_en | (snap_data[cond_sel] ^ cond_pol).
  - Always evaluated against the captured snapshot, never against partially edited buffer contents.
  - `do_write`=0 outside EDIT.
- Output drive:
  - All control outputs are decoded from registered state, `pc` and slot contents only. No combinational path from `in_valid`/`in_data`.
  - Outside EDIT, `addr`/`val` are 0.
- Program length: `cfg_len` > DEPTH saturates to DEPTH.
- Config writes:
  - Accepted only in IDLE. Writes while `busy`=1 are silently dropped.
  - If `cfg_we` and `in_valid` arrive in the same IDLE cycle, the write lands and the program is read starting in EDIT, so the new slot is used.
- Later slots overwrite earlier ones: duplicate `addr` entries are permitted, and the later slot wins if its condition holds.
- Reset:
  - Clears state to IDLE, `pc`=0, `prog_len`=0, `snap_data`=0.
  - All outputs reset to 0 except `in_ready`, which is 1.
  - Slot storage is not reset; `prog_len`=0 makes it inert.
  - Reset mid-transaction aborts with no `out_valid`.

## Timing
- Accept edge at cycle 0. LOAD in cycle 1, EDIT in cycles 2..L+1, DONE in cycle L+2, where L=`prog_len`.
- Total latency from accept to `out_valid` is L+2 cycles. Back-to-back throughput is one word per L+3 cycles.
- The downstream buffer updates on the edge ending each LOAD/EDIT cycle. The result is therefore stable while `out_valid`=1.
- `busy` = state≠IDLE. `in_ready` = !busy.

## Structure
- Shared package holds:
  - FSM state enum (IDLE, LOAD, EDIT, DONE)
  - instruction field offsets and 13-bit instruction width
  - data width 32
  - bit-address width 5
- Natural sub-module: `edit_prog_mem`, a DEPTH×13 register file with one write port and one asynchronous read port, plus the `prog_len` register with saturation.
- The FSM, snapshot register and condition evaluation stay in the top module.

## Test plan
- Empty program, L=0, `in_data`=0xA5A5_5A5A:
  - LOAD strobe in cycle 1, `out_valid` in cycle 2.
  - Downstream buffer = 0xA5A5_5A5A.
- Two unconditional slots, {addr 0, val 1} and {addr 31, val 0}, `in_data`=0x8000_0000:
  - Edits in cycles 2 and 3, `out_valid` in cycle 4.
  - Buffer = 0x0000_0001.
- Conditional slot {cond_en=1, pol=0, sel=4, addr 8, val 1}, run twice:
  - `in_data`=0x10: `do_write`=1, buffer = 0x110.
  - `in_data`=0x0: `do_write`=0, buffer = 0x0.
- Condition uses the snapshot, not edited data:
  - Slot0 {addr 4, val 0}, slot1 {cond on bit 4, addr 5, val 1}, `in_data`=0x10.
  - Result is 0x20.
- `cfg_we` asserted while busy:
  - Slot contents unchanged.
  - Next transaction uses the old program.
- `reset` asserted in an EDIT cycle with L=8:
  - Outputs go to 0 immediately, `in_ready`=1, no `out_valid`.
  - After release, `prog_len` reads as 0: a new word yields LOAD→DONE.

Source files
------------

// File: rtl/edit_sequencer_pkg.sv
// Shared types and constants for the edit sequencer: FSM encoding,
// edit-instruction field layout and the data/bit-address widths.
package edit_sequencer_pkg;

   localparam int DATA_W  = 32;
   localparam int BADDR_W = 5;
   localparam int INSTR_W = 13;

   // Instruction layout: {cond_en, cond_pol, cond_sel[4:0], val, addr[4:0]}
   localparam int F_ADDR_LO = 0;
   localparam int F_VAL     = 5;
   localparam int F_SEL_LO  = 6;
   localparam int F_POL     = 11;
   localparam int F_EN      = 12;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_EDIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Edit condition; always judged against the captured snapshot so that
   // earlier edits in the same program cannot influence later conditions.
   function automatic logic cond_pass(input logic [INSTR_W-1:0] ins,
                                      input logic [DATA_W-1:0]  snap);
      return !ins[F_EN] | (snap[ins[F_SEL_LO +: BADDR_W]] ^ ins[F_POL]);
   endfunction

endpackage

// File: rtl/edit_sequencer_if.sv
// Config, intercept and downstream-buffer control bundle of the edit sequencer.
interface edit_sequencer_if
   import edit_sequencer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) ();

   logic                 cfg_we;
   logic [IDX_W-1:0]     cfg_idx;
   logic [INSTR_W-1:0]   cfg_instr;
   logic                 cfg_len_we;
   logic [IDX_W:0]       cfg_len;
   logic                 in_valid;
   logic [DATA_W-1:0]    in_data;
   logic                 in_ready;
   logic [DATA_W-1:0]    snap_data;
   logic [BADDR_W-1:0]   addr;
   logic                 val;
   logic                 do_write;
   logic                 en_edit;
   logic                 en_load_input;
   logic                 mux_data;
   logic                 busy;
   logic                 out_valid;

   // Sequencer side
   modport slave (
      input  cfg_we, cfg_idx, cfg_instr, cfg_len_we, cfg_len, in_valid, in_data,
      output in_ready, snap_data, addr, val, do_write, en_edit, en_load_input,
             mux_data, busy, out_valid
   );

   // Producer / observer side
   modport master (
      output cfg_we, cfg_idx, cfg_instr, cfg_len_we, cfg_len, in_valid, in_data,
      input  in_ready, snap_data, addr, val, do_write, en_edit, en_load_input,
             mux_data, busy, out_valid
   );

endinterface

// File: rtl/edit_sequencer_prog_mem.sv
// Edit program storage: DEPTH x INSTR_W register file (one write port, one
// asynchronous read port) plus the program-length register.
module edit_prog_mem
   import edit_sequencer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [IDX_W-1:0]   widx,
   input  logic [INSTR_W-1:0] wdata,
   input  logic               len_we,
   input  logic [IDX_W:0]     len_in,
   input  logic [IDX_W-1:0]   ridx,
   output logic [INSTR_W-1:0] rdata,
   output logic [IDX_W:0]     prog_len
);

   localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(DEPTH);

   logic [INSTR_W-1:0] mem [DEPTH];

   // Slot storage is deliberately not reset; a zero program length keeps it inert.
   always_ff @(posedge clk) begin
      if (we) mem[widx] <= wdata;
   end

   assign rdata = mem[ridx];

   // Program length, saturated to the number of physical slots.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       prog_len <= '0;
      else if (len_we) prog_len <= (len_in > LEN_MAX) ? LEN_MAX : len_in;
   end

endmodule

// File: rtl/edit_sequencer.sv
// Edit sequencer: captures one intercepted word, then strobes a bulk load
// followed by one conditional single-bit edit per programmed slot.
module edit_sequencer
   import edit_sequencer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input logic             clk,
   input logic             reset,
   edit_sequencer_if.slave bus
);

   state_t              state;
   logic [IDX_W-1:0]    pc;
   logic [IDX_W:0]      prog_len;
   logic [DATA_W-1:0]   snap;
   logic [INSTR_W-1:0]  cur;
   logic                cfg_ok;
   logic                last;

   logic in_ready_q, busy_q, en_load_q, en_edit_q, mux_q, out_valid_q;

   // Config is only honoured between transactions.
   assign cfg_ok = (state == S_IDLE);
   assign last   = ({1'b0, pc} == (prog_len - 1'b1));

   edit_prog_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_prog (
      .clk      (clk),
      .reset    (reset),
      .we       (bus.cfg_we & cfg_ok),
      .widx     (bus.cfg_idx),
      .wdata    (bus.cfg_instr),
      .len_we   (bus.cfg_len_we & cfg_ok),
      .len_in   (bus.cfg_len),
      .ridx     (pc),
      .rdata    (cur),
      .prog_len (prog_len)
   );

   // Transaction FSM with registered strobes; snapshot and pc live here too.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         pc          <= '0;
         snap        <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         en_load_q   <= 1'b0;
         en_edit_q   <= 1'b0;
         mux_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  snap       <= bus.in_data;
                  pc         <= '0;
                  state      <= S_LOAD;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  en_load_q  <= 1'b1;
               end
            end
            S_LOAD: begin
               en_load_q <= 1'b0;
               if (prog_len != '0) begin
                  state     <= S_EDIT;
                  en_edit_q <= 1'b1;
                  mux_q     <= 1'b1;
               end else begin
                  state       <= S_DONE;
                  out_valid_q <= 1'b1;
               end
            end
            S_EDIT: begin
               pc <= pc + 1'b1;
               if (last) begin
                  state       <= S_DONE;
                  en_edit_q   <= 1'b0;
                  mux_q       <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            default: begin
               state       <= S_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   // Edit fields decode from the current slot, forced to 0 outside EDIT.
   always_comb begin
      bus.addr     = '0;
      bus.val      = 1'b0;
      bus.do_write = 1'b0;
      if (en_edit_q) begin
         bus.addr     = cur[F_ADDR_LO +: BADDR_W];
         bus.val      = cur[F_VAL];
         bus.do_write = cond_pass(cur, snap);
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.busy          = busy_q;
   assign bus.en_load_input = en_load_q;
   assign bus.en_edit       = en_edit_q;
   assign bus.mux_data      = mux_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.snap_data     = snap;

endmodule
